// File: rtl/candidate_generator.sv
// Base-62 alphanumeric candidate generator feeding the Skein-1024 input register.
// Issues one clear per run, then one ASCII-packed candidate write per accepted ISSUE slot.
module candidate_generator #(
  parameter int unsigned NUM_CHARS = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic                   stop_i,
  input  logic [6*NUM_CHARS-1:0] seed_i,
  input  logic                   ready_i,
  output logic                   zero_o,
  output logic                   write_o,
  output logic [1023:0]          state_o,
  output logic                   busy_o,
  output logic                   wrapped_o,
  output logic [63:0]            count_o
);

  typedef enum logic [1:0] {StIdle, StClear, StIssue, StGap} state_e;

  state_e                      r_state, w_state_next;
  logic [NUM_CHARS-1:0][5:0]   r_digits, w_digits_inc, w_digits_seed;
  logic [1023:0]               r_block, w_block;
  logic [63:0]                 r_count;
  logic                        r_wrapped;
  logic                        r_wrap_pend;
  logic                        w_all61;
  logic                        w_load;
  logic                        w_issue;

  function automatic logic [7:0] to_ascii(input logic [5:0] d);
    if (d < 6'd10)      return 8'h30 + {2'b00, d};
    else if (d < 6'd36) return 8'h41 + {2'b00, d} - 8'd10;
    else                return 8'h61 + {2'b00, d} - 8'd36;
  endfunction

  always_comb begin
    for (int unsigned k = 0; k < NUM_CHARS; k++) begin
      w_digits_seed[k] = (seed_i[6*k +: 6] >= 6'd62) ? 6'd0 : seed_i[6*k +: 6];
    end
  end

  // Ripple add of one; the final carry marks an all-61 block (counter wrap).
  always_comb begin : inc
    logic c;
    c = 1'b1;
    for (int unsigned k = 0; k < NUM_CHARS; k++) begin
      if (c && r_digits[k] == 6'd61) begin
        w_digits_inc[k] = 6'd0;
      end else if (c) begin
        w_digits_inc[k] = r_digits[k] + 6'd1;
        c = 1'b0;
      end else begin
        w_digits_inc[k] = r_digits[k];
      end
    end
    w_all61 = c;
  end

  always_comb begin
    w_block = '0;
    for (int unsigned k = 0; k < NUM_CHARS; k++) begin
      w_block[8*k +: 8] = to_ascii(r_digits[k]);
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_issue      = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (start_i) begin
          w_load       = 1'b1;
          w_state_next = StClear;
        end
      end
      StClear: w_state_next = StIssue;
      StIssue: begin
        if (stop_i) begin
          w_state_next = StIdle;
        end else if (ready_i) begin
          w_issue      = 1'b1;
          w_state_next = StGap;
        end
      end
      StGap:   w_state_next = r_wrap_pend ? StIdle : StIssue;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= StIdle;
      r_digits    <= '0;
      r_block     <= '0;
      r_count     <= '0;
      r_wrapped   <= 1'b0;
      r_wrap_pend <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_load) begin
        r_digits    <= w_digits_seed;
        r_count     <= '0;
        r_wrapped   <= 1'b0;
        r_wrap_pend <= 1'b0;
      end
      if (w_issue) begin
        r_block     <= w_block;
        r_digits    <= w_digits_inc;
        r_count     <= r_count + 64'd1;
        r_wrap_pend <= w_all61;
      end
      if (r_state == StGap && r_wrap_pend) begin
        r_wrapped <= 1'b1;
      end
    end
  end

  // Pulses decode straight from state so reset removes them asynchronously.
  assign zero_o    = (r_state == StClear);
  assign write_o   = (r_state == StGap);
  assign busy_o    = (r_state != StIdle);
  assign state_o   = r_block;
  assign wrapped_o = r_wrapped;
  assign count_o   = r_count;

endmodule
